// File: rtl/spi_pkg.sv
// Shared types and mode decoding for the SPI slave.
package spi_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } spi_state_t;

  function automatic logic spi_cpol(input int mode);
    return (mode == 2) || (mode == 3);
  endfunction

  function automatic logic spi_cpha(input int mode);
    return (mode == 1) || (mode == 3);
  endfunction

endpackage

// File: rtl/spi_sync.sv
// Parameterised 2-flop synchronizer with an asynchronous preset/clear value.
module spi_sync #(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         i_Clk,
  input  logic         i_Rst,
  input  logic [W-1:0] i_D,
  output logic [W-1:0] o_Q
);

  logic [W-1:0] meta;

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      meta <= RST_VAL;
      o_Q  <= RST_VAL;
    end else begin
      meta <= i_D;
      o_Q  <= meta;
    end
  end

endmodule

// File: rtl/spi_slave.sv
// SPI slave oversampled by i_Clk: pins are synchronized, edges detected in the
// system domain, one TX holding register in front of the TX shift register.
module spi_slave
  import spi_pkg::*;
#(
  parameter int SPI_MODE = 0
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic [7:0] i_TX_Byte,
  input  logic       i_TX_DV,
  output logic       o_TX_Ready,
  output logic       o_RX_DV,
  output logic [7:0] o_RX_Byte,
  input  logic       i_SPI_Clk,
  input  logic       i_SPI_CS_n,
  input  logic       i_SPI_MOSI,
  output logic       o_SPI_MISO,
  output logic       o_SPI_MISO_En
);

  localparam logic CPOL = spi_cpol(SPI_MODE);
  localparam logic CPHA = spi_cpha(SPI_MODE);

  logic [2:0] sync_q;
  logic       sclk_s, cs_n_s, mosi_s;
  logic       sclk_q, cs_n_q;
  logic [1:0] flush_pipe;
  logic       armed;

  spi_state_t state_q, state_d;
  logic [2:0] bit_cnt;
  logic [7:0] rx_shift, tx_shift, hold_byte;
  logic       hold_full;

  logic sclk_rise, sclk_fall, lead, trail;
  logic cs_fall, cs_rise, active, cs_exit;
  logic sample, load, shift;

  spi_sync #(
    .W       (3),
    .RST_VAL ({CPOL, 1'b1, 1'b0})
  ) u_sync (
    .i_Clk (i_Clk),
    .i_Rst (i_Rst),
    .i_D   ({i_SPI_Clk, i_SPI_CS_n, i_SPI_MOSI}),
    .o_Q   (sync_q)
  );

  assign sclk_s = sync_q[2];
  assign cs_n_s = sync_q[1];
  assign mosi_s = sync_q[0];

  // A frame may only start once CS_n has been seen high with real pin data
  // behind the synchronizer, so a reset in mid-frame cannot re-enter it.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      sclk_q     <= CPOL;
      cs_n_q     <= 1'b1;
      flush_pipe <= '0;
      armed      <= 1'b0;
    end else begin
      sclk_q     <= sclk_s;
      cs_n_q     <= cs_n_s;
      flush_pipe <= {flush_pipe[0], 1'b1};
      if (flush_pipe[1] && cs_n_s) armed <= 1'b1;
    end
  end

  assign sclk_rise = sclk_s & ~sclk_q;
  assign sclk_fall = ~sclk_s & sclk_q;
  assign lead      = CPOL ? sclk_fall : sclk_rise;
  assign trail     = CPOL ? sclk_rise : sclk_fall;
  assign cs_fall   = armed & cs_n_q & ~cs_n_s;
  assign cs_rise   = ~cs_n_q & cs_n_s;
  assign active    = (state_q == ST_ACTIVE);
  assign cs_exit   = active & cs_rise;

  assign sample = active & ~cs_exit & (CPHA ? trail : lead);
  assign load   = CPHA ? (active & ~cs_exit & lead & (bit_cnt == 3'd0))
                       : ((~active & cs_fall) |
                          (active & ~cs_exit & trail & (bit_cnt == 3'd0)));
  assign shift  = active & ~cs_exit & ~load & (CPHA ? lead : trail);

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (cs_fall) state_d = ST_ACTIVE;
      ST_ACTIVE: if (cs_rise) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      bit_cnt   <= '0;
      rx_shift  <= '0;
      tx_shift  <= '0;
      o_RX_DV   <= 1'b0;
      o_RX_Byte <= '0;
    end else begin
      o_RX_DV <= 1'b0;
      if (cs_exit) begin
        bit_cnt  <= '0;
        rx_shift <= '0;
        tx_shift <= '0;
      end else begin
        if (sample) begin
          rx_shift <= {rx_shift[6:0], mosi_s};
          bit_cnt  <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            o_RX_Byte <= {rx_shift[6:0], mosi_s};
            o_RX_DV   <= 1'b1;
          end
        end
        if (load)       tx_shift <= hold_full ? hold_byte : 8'h00;
        else if (shift) tx_shift <= {tx_shift[6:0], 1'b0};
      end
    end
  end

  // A write landing on the same cycle as a load of an empty holder is kept
  // for the following byte; the current byte goes out as 0x00.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      hold_byte <= '0;
      hold_full <= 1'b0;
    end else begin
      if (load) hold_full <= 1'b0;
      if (i_TX_DV && !hold_full) begin
        hold_byte <= i_TX_Byte;
        hold_full <= 1'b1;
      end
    end
  end

  assign o_TX_Ready    = ~hold_full;
  assign o_SPI_MISO    = active & tx_shift[7];
  assign o_SPI_MISO_En = active;

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: one instance per SPI mode, a bit-banged master, and
// queues of expected RX/MISO bytes checked as the DUT produces them.
module tb_spi_slave;

  localparam time HP = 40ns;

  logic       i_Clk = 1'b0;
  logic       i_Rst;
  logic [7:0] tx_byte;
  logic [3:0] tx_dv, tx_ready, rx_dv, sclk, cs_n, mosi, miso, miso_en;
  logic [7:0] rx_byte [4];

  always #5ns i_Clk = ~i_Clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    spi_slave #(.SPI_MODE(g)) dut (
      .i_Clk         (i_Clk),
      .i_Rst         (i_Rst),
      .i_TX_Byte     (tx_byte),
      .i_TX_DV       (tx_dv[g]),
      .o_TX_Ready    (tx_ready[g]),
      .o_RX_DV       (rx_dv[g]),
      .o_RX_Byte     (rx_byte[g]),
      .i_SPI_Clk     (sclk[g]),
      .i_SPI_CS_n    (cs_n[g]),
      .i_SPI_MOSI    (mosi[g]),
      .o_SPI_MISO    (miso[g]),
      .o_SPI_MISO_En (miso_en[g])
    );
  end

  int         checks   = 0;
  int         failures = 0;
  int         dv_cnt   = 0;
  logic [7:0] exp_rx_q[$];
  logic [7:0] exp_miso_q[$];
  logic [7:0] mon_exp;

  typedef struct {
    int         mode;
    logic [7:0] host;
    logic [7:0] mo;
    logic [7:0] exp_miso;
    logic [7:0] exp_rx;
  } vec_t;

  vec_t vecs[8];

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge i_Clk) begin
    for (int m = 0; m < 4; m++) begin
      if (rx_dv[m] === 1'b1) begin
        dv_cnt++;
        if (exp_rx_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL rx_dv_unexpected: mode %0d byte %h, expected no pulse", m, rx_byte[m]);
        end else begin
          mon_exp = exp_rx_q.pop_front();
          check8("rx_byte", rx_byte[m], mon_exp);
        end
      end
    end
  end

  task automatic write_tx(input int m, input logic [7:0] b);
    @(posedge i_Clk); #1;
    tx_byte  = b;
    tx_dv[m] = 1'b1;
    @(posedge i_Clk); #1;
    tx_dv[m] = 1'b0;
  endtask

  task automatic cs_low(input int m);
    cs_n[m] = 1'b0;
    #(2*HP);
  endtask

  task automatic cs_high(input int m);
    #HP;
    cs_n[m] = 1'b1;
    #(2*HP);
  endtask

  task automatic xfer(input int m, input logic [7:0] mo, input int nbits, output logic [7:0] mi);
    logic [1:0] md;
    md = m[1:0];
    mi = '0;
    for (int i = 7; i > 7 - nbits; i--) begin
      if (!md[0]) begin
        mosi[m] = mo[i];
        #HP;
        sclk[m] = ~md[1];
        mi[i]   = miso[m];
        #HP;
        sclk[m] = md[1];
      end else begin
        sclk[m] = ~md[1];
        mosi[m] = mo[i];
        #HP;
        sclk[m] = md[1];
        mi[i]   = miso[m];
        #HP;
      end
    end
  endtask

  task automatic byte_chk(input int m, input logic [7:0] mo);
    logic [7:0] got;
    exp_rx_q.push_back(mo);
    xfer(m, mo, 8, got);
    check8("miso_byte", got, exp_miso_q.pop_front());
  endtask

  task automatic run_frame(input vec_t v);
    int d0;
    write_tx(v.mode, v.host);
    check8("tx_ready_after_write", {7'b0, tx_ready[v.mode]}, 8'h00);
    exp_miso_q.push_back(v.exp_miso);
    cs_low(v.mode);
    check8("miso_en_active", {7'b0, miso_en[v.mode]}, 8'h01);
    d0 = dv_cnt;
    exp_rx_q.push_back(v.exp_rx);
    begin
      logic [7:0] got;
      xfer(v.mode, v.mo, 8, got);
      check8("miso_byte", got, exp_miso_q.pop_front());
    end
    cs_high(v.mode);
    check8("rx_dv_count", 8'(dv_cnt - d0), 8'd1);
    check8("miso_en_idle", {7'b0, miso_en[v.mode]}, 8'h00);
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int         d0;
    logic [7:0] junk;

    vecs[0] = '{0, 8'hA5, 8'h3C, 8'hA5, 8'h3C};
    vecs[1] = '{1, 8'hA5, 8'h3C, 8'hA5, 8'h3C};
    vecs[2] = '{2, 8'hA5, 8'h3C, 8'hA5, 8'h3C};
    vecs[3] = '{3, 8'hA5, 8'h3C, 8'hA5, 8'h3C};
    vecs[4] = '{0, 8'hFF, 8'h00, 8'hFF, 8'h00};
    vecs[5] = '{1, 8'h00, 8'hFF, 8'h00, 8'hFF};
    vecs[6] = '{2, 8'h5A, 8'hC3, 8'h5A, 8'hC3};
    vecs[7] = '{3, 8'hC3, 8'h5A, 8'hC3, 8'h5A};

    i_Rst   = 1'b1;
    sclk    = 4'b1100;
    cs_n    = 4'hF;
    mosi    = 4'h0;
    tx_dv   = 4'h0;
    tx_byte = 8'h00;
    repeat (3) @(posedge i_Clk);
    #1;
    for (int m = 0; m < 4; m++) begin
      check8("rst_tx_ready", {7'b0, tx_ready[m]}, 8'h01);
      check8("rst_outs", {rx_dv[m], miso[m], miso_en[m], 5'b0}, 8'h00);
      check8("rst_rx_byte", rx_byte[m], 8'h00);
    end
    #2 i_Rst = 1'b0;
    repeat (5) @(posedge i_Clk);

    for (int i = 0; i < 8; i++) run_frame(vecs[i]);

    // three bytes in one frame, only two written
    write_tx(0, 8'h11);
    exp_miso_q.push_back(8'h11);
    cs_low(0);
    write_tx(0, 8'h22);
    exp_miso_q.push_back(8'h22);
    exp_miso_q.push_back(8'h00);
    d0 = dv_cnt;
    byte_chk(0, 8'hDE);
    byte_chk(0, 8'hAD);
    byte_chk(0, 8'hBE);
    cs_high(0);
    check8("rx_dv_count_3byte", 8'(dv_cnt - d0), 8'd3);

    // write while holder is full is dropped
    write_tx(0, 8'h55);
    write_tx(0, 8'h77);
    check8("tx_ready_still_full", {7'b0, tx_ready[0]}, 8'h00);
    exp_miso_q.push_back(8'h55);
    cs_low(0);
    byte_chk(0, 8'h12);
    cs_high(0);

    // CS raised after 5 bits: no RX byte, holder retained for next frame
    cs_low(0);
    write_tx(0, 8'h99);
    d0 = dv_cnt;
    xfer(0, 8'hFF, 5, junk);
    cs_high(0);
    check8("rx_dv_partial", 8'(dv_cnt - d0), 8'd0);
    check8("tx_ready_retained", {7'b0, tx_ready[0]}, 8'h00);
    exp_miso_q.push_back(8'h99);
    cs_low(0);
    d0 = dv_cnt;
    byte_chk(0, 8'h81);
    cs_high(0);
    check8("rx_dv_after_partial", 8'(dv_cnt - d0), 8'd1);

    // reset pulsed mid-byte in mode 1
    write_tx(1, 8'h66);
    cs_low(1);
    xfer(1, 8'hF0, 3, junk);
    write_tx(1, 8'h44);
    check8("pre_rst_miso", {7'b0, miso[1]}, 8'h01);
    @(posedge i_Clk);
    #2 i_Rst = 1'b1;
    #1;
    check8("midrst_tx_ready", {7'b0, tx_ready[1]}, 8'h01);
    check8("midrst_outs", {rx_dv[1], miso[1], miso_en[1], 5'b0}, 8'h00);
    check8("midrst_rx_byte", rx_byte[1], 8'h00);
    #20 i_Rst = 1'b0;
    repeat (10) @(posedge i_Clk);
    #1;
    check8("no_resume_cs_low", {7'b0, miso_en[1]}, 8'h00);
    cs_n[1] = 1'b1;
    #(2*HP);
    run_frame('{1, 8'hC7, 8'h29, 8'hC7, 8'h29});

    repeat (10) @(posedge i_Clk);
    check8("rx_queue_drained", 8'(exp_rx_q.size()), 8'd0);
    check8("miso_queue_drained", 8'(exp_miso_q.size()), 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 SHALL have parameter SPI_MODE, default 0, meaning SPI mode 0-3 (CPOL = mode 2/3, CPHA = mode 1/3).
REQ-002 SHALL have port i_Clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-003 SHALL have port i_Rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port i_TX_Byte, input, 8 bits: next byte to return on MISO.
REQ-005 SHALL have port i_TX_DV, input, 1 bit: one-cycle write strobe for i_TX_Byte.
REQ-006 SHALL have port o_TX_Ready, output, 1 bit: TX holding register empty.
REQ-007 SHALL have port o_RX_DV, output, 1 bit: one-cycle pulse marking o_RX_Byte valid.
REQ-008 SHALL have port o_RX_Byte, output, 8 bits: last complete byte received on MOSI.
REQ-009 SHALL have port i_SPI_Clk, input, 1 bit: master SCLK, asynchronous to i_Clk.
REQ-010 SHALL have port i_SPI_CS_n, input, 1 bit: chip select, active-low, asynchronous.
REQ-011 SHALL have port i_SPI_MOSI, input, 1 bit: serial data from the master.
REQ-012 SHALL have port o_SPI_MISO, output, 1 bit: serial data to the master.
REQ-013 SHALL have port o_SPI_MISO_En, output, 1 bit: MISO output enable for the top-level tristate.

Function
REQ-014 SHALL pass i_SPI_Clk, i_SPI_CS_n and i_SPI_MOSI through 2-flop synchronizers; all edges are detected on the synchronized values.
REQ-015 SHALL require i_Clk >= 8x the SCLK frequency; behaviour below this ratio is undefined.
REQ-016 SHALL implement FSM IDLE/ACTIVE: IDLE->ACTIVE on synced CS_n falling; ACTIVE->IDLE on synced CS_n rising.
REQ-017 SHALL define the leading edge as rising for CPOL=0 and falling for CPOL=1; the trailing edge is the opposite edge.
REQ-018 SHALL ignore SCLK edges while in IDLE.
REQ-019 SHALL sample MOSI on the leading edge (CPHA=0) or the trailing edge (CPHA=1), MSB first, into the RX shift register.
REQ-020 SHALL copy the RX shift register to o_RX_Byte on the 8th sample of a byte and pulse o_RX_DV for exactly 1 cycle, no later than 4 i_Clk cycles after the pin edge.
REQ-021 SHALL reset the 3-bit bit counter after 8 samples (wrap 7->0), so multiple bytes per CS frame are supported.
REQ-022 SHALL perform a byte-load event for CPHA=0 on CS assertion and on the 8th trailing edge of each byte, and for CPHA=1 on the 1st leading edge of each byte.
REQ-023 SHALL, at a byte-load event, move the holding register into the TX shift register and set o_TX_Ready=1; if the holding register is empty, it SHALL load 0x00.
REQ-024 SHALL drive o_SPI_MISO from the TX shift register MSB, shifting left on the trailing edge (CPHA=0) or the leading edge (CPHA=1), except at a load event.
REQ-025 SHALL, when i_TX_DV=1 and o_TX_Ready=1, capture i_TX_Byte into the holding register and set o_TX_Ready=0 on the next cycle; i_TX_DV SHALL be ignored while o_TX_Ready=0.
REQ-026 SHALL, when i_TX_DV coincides with a load event on an empty holding register, transmit 0x00 for the current byte and hold the written byte for the next byte.
REQ-027 SHALL assert o_SPI_MISO_En=1 only in ACTIVE; in IDLE, o_SPI_MISO SHALL be 0.
REQ-028 SHALL, on CS deassertion mid-byte, discard the partial RX byte (no o_RX_DV), clear the bit counter and both shift registers, and retain the holding register.

Reset
REQ-029 SHALL, while i_Rst=1, asynchronously set: FSM=IDLE, o_TX_Ready=1, o_RX_DV=0, o_RX_Byte=0x00, o_SPI_MISO=0, o_SPI_MISO_En=0, counters and shift registers 0, synchronizers to the idle levels (CS_n=1, SCLK=CPOL).
REQ-030 SHALL, on reset mid-frame, abort the transfer; the block SHALL resume only at the next CS falling edge after reset release.

Structure
REQ-031 SHALL place the FSM state enum and the CPOL/CPHA derivation functions in package spi_pkg.
REQ-032 SHALL use one sub-module, spi_sync: a parameterised-width 2-flop synchronizer with an asynchronous, active-high reset value.

Verification
REQ-033 SHALL cover: mode 0, host writes 0xA5, master sends 0x3C -> MISO bits 10100101, o_RX_Byte=0x3C, one o_RX_DV pulse.
REQ-034 SHALL cover: modes 1, 2 and 3 each with the 0xA5/0x3C exchange -> identical byte results in every mode.
REQ-035 SHALL cover: 3-byte frame with only 0x11 and 0x22 written -> MISO returns 0x11, 0x22, 0x00; three o_RX_DV pulses.
REQ-036 SHALL cover: i_TX_DV with 0x77 while o_TX_Ready=0 -> write ignored and the earlier byte transmitted.
REQ-037 SHALL cover: CS deasserted after 5 bits, then a new frame sending 0x81 -> no o_RX_DV for the partial byte; next o_RX_Byte=0x81.
REQ-038 SHALL cover: i_Rst pulsed mid-byte -> all outputs at reset values within the same cycle; the next frame transfers correctly.
